config_access_arbiter: RTL and testbench

- Sole write/read master for the TPU configuration register file.
- Arbitrates between two requesters: host debug port (requester 0, UART/host bridge) and instruction controller (requester 1).
- Holds each write until the datapath is quiescent, so activation, accumulate, normalize and quantize settings never change mid-operation.
- Returns one response per request: read data or error.

---
 rtl/cfg_pkg.sv | 29 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/config_access_arbiter.sv | 142 ++++++++++++++
 tb/tb_config_access_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the TPU configuration access path: register map,
// requester identities and the arbiter state encoding.
package cfg_pkg;

    // Implemented configuration registers
    localparam int unsigned NUM_CFG_REGS = 4;

    localparam logic [7:0] CFG_ADDR_VPU_ACT   = 8'h00;  // VPU activation type
    localparam logic [7:0] CFG_ADDR_CLR_ACC   = 8'h01;  // clear accumulator
    localparam logic [7:0] CFG_ADDR_NORM_EN   = 8'h02;  // normalization enable
    localparam logic [7:0] CFG_ADDR_QUANT_EN  = 8'h03;  // quantization enable

    // Requester identities (bit index into the per-requester port vectors)
    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_CTRL = 1'b1;

    // Arbiter FSM state encoding
    typedef logic [1:0] cfg_state_t;
    localparam cfg_state_t ST_IDLE       = 2'd0;
    localparam cfg_state_t ST_WAIT_QUIET = 2'd1;
    localparam cfg_state_t ST_EXEC       = 2'd2;
    localparam cfg_state_t ST_RESP       = 2'd3;

    // One-hot response/ready vector for a requester id
    function automatic logic [1:0] req_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational; the priority pointer
// moves to the non-granted requester whenever a grant is accepted.
module rr_arbiter2
    import cfg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic ptr;

    // Pointer requester wins a tie; a lone requester always wins
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // Pointer hands priority to the other requester after each accept
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= REQ_HOST;
        end else if (accept) begin
            ptr <= ~grant[1];
        end
    end

endmodule

// File: rtl/config_access_arbiter.sv
// Sole master of the configuration register file. Serialises host and
// instruction-controller accesses, defers writes until the datapath is idle
// and returns exactly one response per accepted request.
module config_access_arbiter
    import cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS       = NUM_CFG_REGS,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_write,
    input  logic [1:0][7:0]  req_addr,
    input  logic [1:0][31:0] req_data,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    input  logic             datapath_busy,
    output logic             cfg_wr_en,
    output logic [7:0]       cfg_reg_addr,
    output logic [31:0]      cfg_reg_data,
    output logic [7:0]       cfg_rd_addr,
    input  logic [31:0]      cfg_rd_data
);

    localparam logic [8:0] NUM_REGS_W   = 9'(NUM_REGS);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    cfg_state_t  state;
    logic        lat_id;
    logic        lat_write;
    logic [7:0]  lat_addr;
    logic [31:0] lat_data;
    logic [7:0]  wait_cnt;

    logic [1:0]  grant;
    logic        handshake;
    logic        gid;
    logic        sel_write;
    logic [7:0]  sel_addr;
    logic [31:0] sel_data;
    logic        sel_bad;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .accept (handshake),
        .grant  (grant)
    );

    // Offer the grant only while idle; select the granted request's fields
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && !reset) begin
            req_ready = grant;
        end
        handshake = |req_ready;
        gid       = req_ready[1];
        sel_write = req_write[gid];
        sel_addr  = req_addr[gid];
        sel_data  = req_data[gid];
        sel_bad   = ({1'b0, sel_addr} >= NUM_REGS_W);
    end

    // Register-file write port and response strobe follow the FSM state
    always_comb begin
        cfg_wr_en    = (state == ST_EXEC) && lat_write;
        cfg_reg_addr = lat_addr;
        cfg_reg_data = lat_data;
        rsp_valid    = (state == ST_RESP) ? req_onehot(lat_id) : 2'b00;
    end

    // Transaction sequencing: accept, wait for quiescence, execute, respond.
    // cfg_rd_addr is loaded on acceptance so it is already valid during EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            lat_id      <= REQ_HOST;
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_data    <= '0;
            wait_cnt    <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            cfg_rd_addr <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        lat_id    <= gid;
                        lat_write <= sel_write;
                        lat_addr  <= sel_addr;
                        lat_data  <= sel_data;
                        if (sel_bad) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                            state    <= ST_RESP;
                        end else if (sel_write && datapath_busy) begin
                            wait_cnt <= '0;
                            state    <= ST_WAIT_QUIET;
                        end else begin
                            if (!sel_write) begin
                                cfg_rd_addr <= sel_addr;
                            end
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_WAIT_QUIET: begin
                    if (!datapath_busy) begin
                        state <= ST_EXEC;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == TIMEOUT_LAST) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_data <= lat_write ? '0 : cfg_rd_data;
                    rsp_err  <= 1'b0;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[lat_id]) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_access_arbiter.sv
// Self-checking bench for config_access_arbiter: directed scenarios with
// literal expectations followed by randomized traffic, all checked every
// cycle against a transaction-level model.
module tb_config_access_arbiter;

    localparam int NREGS = 4;
    localparam int TMO   = 255;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_write;
    logic [1:0][7:0]  req_addr;
    logic [1:0][31:0] req_data;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic             datapath_busy;
    logic             cfg_wr_en;
    logic [7:0]       cfg_reg_addr;
    logic [31:0]      cfg_reg_data;
    logic [7:0]       cfg_rd_addr;
    logic [31:0]      cfg_rd_data;

    config_access_arbiter #(
        .NUM_REGS       (NREGS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .datapath_busy (datapath_busy),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_reg_addr  (cfg_reg_addr),
        .cfg_reg_data  (cfg_reg_data),
        .cfg_rd_addr   (cfg_rd_addr),
        .cfg_rd_data   (cfg_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Transaction-level model: one outstanding transaction, described by the
    // absolute cycle of its register access and of its first response cycle.
    bit          m_have;
    bit          m_write;
    bit          m_waiting;
    bit          m_err;
    int          m_id;
    int          m_ptr;
    int          m_waited;
    int          m_exec;
    int          m_rsp;
    logic [7:0]  m_addr;
    logic [7:0]  m_rd_addr;
    logic [31:0] m_data;
    logic [31:0] m_rdata;
    logic [1:0]  m_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int grantee(input logic [1:0] v, input int ptr);
        if (v == 2'b11) return ptr;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    // One clock cycle: compare DUT against the model, advance the model,
    // then move to the next negedge where the caller drives fresh inputs.
    task automatic cycle();
        int         g;
        logic [1:0] exp_ready;
        logic [1:0] exp_rv;
        bit         exp_wr;
        #1;
        m_acc = 2'b00;
        if (reset) begin
            m_have    = 0;
            m_waiting = 0;
            m_ptr     = 0;
            m_rd_addr = '0;
        end else begin
            g = grantee(req_valid, m_ptr);
            exp_ready = 2'b00;
            if (!m_have && g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_ready));

            exp_rv = 2'b00;
            if (m_have && m_rsp >= 0 && cyc >= m_rsp) exp_rv[m_id] = 1'b1;
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv != 2'b00) begin
                check("rsp_data", rsp_data, m_rdata);
                check("rsp_err", 32'(rsp_err), 32'(m_err));
            end

            exp_wr = m_have && m_write && (cyc == m_exec);
            check("cfg_wr_en", 32'(cfg_wr_en), 32'(exp_wr));
            if (exp_wr) begin
                check("cfg_reg_addr", 32'(cfg_reg_addr), 32'(m_addr));
                check("cfg_reg_data", cfg_reg_data, m_data);
            end
            check("cfg_rd_addr", 32'(cfg_rd_addr), 32'(m_rd_addr));

            if (m_have) begin
                if (m_waiting) begin
                    if (!datapath_busy) begin
                        m_waiting = 0;
                        m_exec    = cyc + 1;
                        m_rsp     = cyc + 2;
                    end else begin
                        m_waited++;
                        if (m_waited == TMO) begin
                            m_waiting = 0;
                            m_err     = 1;
                            m_rsp     = cyc + 1;
                        end
                    end
                end else if (cyc == m_exec && !m_write) begin
                    m_rdata = cfg_rd_data;
                end
                if (m_rsp >= 0 && cyc >= m_rsp && rsp_ready[m_id]) m_have = 0;
            end else if (g >= 0) begin
                m_have    = 1;
                m_acc[g]  = 1'b1;
                m_id      = g;
                m_write   = req_write[g];
                m_addr    = req_addr[g];
                m_data    = req_data[g];
                m_ptr     = 1 - g;
                m_err     = 0;
                m_rdata   = '0;
                m_waiting = 0;
                m_waited  = 0;
                m_exec    = -1;
                m_rsp     = -1;
                if (int'(m_addr) >= NREGS) begin
                    m_err = 1;
                    m_rsp = cyc + 1;
                end else if (m_write && datapath_busy) begin
                    m_waiting = 1;
                end else begin
                    m_exec = cyc + 1;
                    m_rsp  = cyc + 2;
                    if (!m_write) m_rd_addr = m_addr;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        req_valid = 2'b00;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_data"}, rsp_data, 32'h0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        check({tag, "_cfg_wr_en"}, 32'(cfg_wr_en), 32'h0);
        check({tag, "_cfg_reg_addr"}, 32'(cfg_reg_addr), 32'h0);
        check({tag, "_cfg_reg_data"}, cfg_reg_data, 32'h0);
        check({tag, "_cfg_rd_addr"}, 32'(cfg_rd_addr), 32'h0);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [31:0] d);
        req_valid   = 2'b01;
        req_write   = 2'b01;
        req_addr[0] = a;
        req_data[0] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        logic [1:0]  exp_g [4];
        logic [31:0] exp_d [4];
        int          hk, ck, gi, wi, rsp_at, wr_seen;
        bit          p_valid [2];
        bit          p_write [2];
        logic [7:0]  p_addr  [2];
        logic [31:0] p_data  [2];

        reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_data = '0;
        rsp_ready = 2'b11; datapath_busy = 1'b0; cfg_rd_data = '0;
        m_have = 0; m_waiting = 0; m_ptr = 0; m_rd_addr = '0; m_exec = -1; m_rsp = -1;
        cycle(); cycle();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Host write, datapath idle
        host_write(8'h00, 32'h5);
        #1 check("hw_ready", 32'(req_ready), 32'h1);
        cycle();
        req_valid = 2'b00;
        #1;
        check("hw_wr_en", 32'(cfg_wr_en), 32'h1);
        check("hw_wr_addr", 32'(cfg_reg_addr), 32'h0);
        check("hw_wr_data", cfg_reg_data, 32'h5);
        cycle();
        #1;
        check("hw_rsp_valid", 32'(rsp_valid), 32'h1);
        check("hw_rsp_err", 32'(rsp_err), 32'h0);
        check("hw_rsp_data", rsp_data, 32'h0);
        cycle();
        #1 check("hw_rsp_drop", 32'(rsp_valid), 32'h0);
        idle(1);

        // Controller read of register 2
        req_valid = 2'b10; req_write = 2'b00; req_addr[1] = 8'h02;
        #1 check("cr_ready", 32'(req_ready), 32'h2);
        cycle();
        req_valid = 2'b00; cfg_rd_data = 32'h1;
        #1;
        check("cr_no_wr", 32'(cfg_wr_en), 32'h0);
        check("cr_rd_addr", 32'(cfg_rd_addr), 32'h2);
        cycle();
        cfg_rd_data = 32'h0;
        #1;
        check("cr_rsp_valid", 32'(rsp_valid), 32'h2);
        check("cr_rsp_data", rsp_data, 32'h1);
        check("cr_rsp_err", 32'(rsp_err), 32'h0);
        cycle();
        idle(1);

        // Both requesters contend for four writes
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{32'h100, 32'h200, 32'h101, 32'h201};
        hk = 0; ck = 0; gi = 0; wi = 0;
        req_write = 2'b11; req_addr[0] = 8'h01; req_addr[1] = 8'h02;
        for (int t = 0; t < 40 && wi < 4; t++) begin
            req_valid   = {ck < 2, hk < 2};
            req_data[0] = 32'h100 + 32'(hk);
            req_data[1] = 32'h200 + 32'(ck);
            #1;
            if (req_ready != 2'b00 && gi < 4) begin
                check("rr_grant", 32'(req_ready), 32'(exp_g[gi]));
                gi++;
            end
            if (cfg_wr_en && wi < 4) begin
                check("rr_wr_data", cfg_reg_data, exp_d[wi]);
                wi++;
            end
            cycle();
            if (m_acc[0]) hk++;
            if (m_acc[1]) ck++;
        end
        check("rr_grants_seen", 32'(gi), 32'd4);
        check("rr_writes_seen", 32'(wi), 32'd4);
        idle(2);

        // Write held off by 10 busy cycles
        datapath_busy = 1'b1;
        host_write(8'h01, 32'h33);
        #1 check("bz_ready", 32'(req_ready), 32'h1);
        cycle();
        req_valid = 2'b00;
        for (int k = 1; k < 10; k++) begin
            #1 check("bz_hold_no_wr", 32'(cfg_wr_en), 32'h0);
            cycle();
        end
        datapath_busy = 1'b0;
        #1 check("bz_fall_no_wr", 32'(cfg_wr_en), 32'h0);
        cycle();
        #1;
        check("bz_wr_en", 32'(cfg_wr_en), 32'h1);
        check("bz_wr_data", cfg_reg_data, 32'h33);
        cycle();
        #1;
        check("bz_rsp_valid", 32'(rsp_valid), 32'h1);
        check("bz_rsp_err", 32'(rsp_err), 32'h0);
        cycle();
        idle(1);

        // Write abandoned after the quiescence timeout
        datapath_busy = 1'b1;
        host_write(8'h03, 32'hdead);
        cycle();
        req_valid = 2'b00;
        rsp_at = -1; wr_seen = 0;
        for (int t = 1; t <= 300; t++) begin
            #1;
            if (cfg_wr_en) wr_seen++;
            if (rsp_valid[0] && rsp_at < 0) begin
                rsp_at = t;
                check("to_rsp_err", 32'(rsp_err), 32'h1);
            end
            cycle();
        end
        check("to_rsp_cycle", 32'(rsp_at), 32'd256);
        check("to_no_write", 32'(wr_seen), 32'd0);
        datapath_busy = 1'b0;
        idle(1);

        // Bad address with a stalled response
        rsp_ready = 2'b00;
        host_write(8'h07, 32'h99);
        cycle();
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("ba_rsp_valid", 32'(rsp_valid), 32'h1);
            check("ba_rsp_err", 32'(rsp_err), 32'h1);
            check("ba_rsp_data", rsp_data, 32'h0);
            check("ba_no_wr", 32'(cfg_wr_en), 32'h0);
            cycle();
        end
        rsp_ready = 2'b11;
        #1 check("ba_rsp_final", 32'(rsp_valid), 32'h1);
        cycle();
        #1 check("ba_rsp_drop", 32'(rsp_valid), 32'h0);
        idle(1);

        // Reset while waiting for quiescence
        datapath_busy = 1'b1;
        host_write(8'h00, 32'h77);
        cycle();
        req_valid = 2'b00;
        idle(3);
        reset = 1'b1;
        cycle();
        reset = 1'b0; datapath_busy = 1'b0;
        check_reset_outputs("rst_wq");
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rst_no_wr", 32'(cfg_wr_en), 32'h0);
            check("rst_no_rsp", 32'(rsp_valid), 32'h0);
            cycle();
        end

        // Randomized traffic
        p_valid = '{0, 0};
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_valid[i] && $urandom_range(0, 3) == 0) begin
                    p_valid[i] = 1;
                    p_write[i] = 1'($urandom_range(0, 1));
                    p_addr[i]  = 8'($urandom_range(0, 5));
                    p_data[i]  = $urandom;
                end else if (p_valid[i] && $urandom_range(0, 15) == 0) begin
                    p_valid[i] = 0;
                end
                req_valid[i] = p_valid[i];
                req_write[i] = p_write[i];
                req_addr[i]  = p_addr[i];
                req_data[i]  = p_data[i];
            end
            if ($urandom_range(0, 7) == 0) datapath_busy = ~datapath_busy;
            rsp_ready   = 2'($urandom_range(0, 3));
            cfg_rd_data = $urandom;
            reset       = ($urandom_range(0, 699) == 0);
            cycle();
            for (int i = 0; i < 2; i++) if (m_acc[i]) p_valid[i] = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
